// File: rtl/prf_ready_regfile_pkg.sv
// Shared sizing and types for the R10K physical register file and its ready table.
// PRF_READ_LAT is exported so issue/RS timing can reference the operand read latency.
package prf_ready_regfile_pkg;
   localparam int PHYS_REG_SZ_R10K = 32;
   localparam int CDB_SZ           = 2;
   localparam int NUM_FU_TOTAL     = 3;
   localparam int N                = 2;
   localparam int PRF_READ_LAT     = 1;
   localparam int DATA_W           = 32;
   localparam int NUM_REGS         = PHYS_REG_SZ_R10K;
   localparam int TAG_W            = $clog2(PHYS_REG_SZ_R10K);

   typedef logic [TAG_W-1:0]  phys_tag_t;
   typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/prf_ready_regfile_if.sv
// Bundles the issue read, CDB write, dispatch alloc and recovery signals of the PRF.
// master drives requests (back-end control); slave is the register file.
interface prf_ready_regfile_if;
   import prf_ready_regfile_pkg::*;

   logic [NUM_FU_TOTAL-1:0]            read_en;
   phys_tag_t [NUM_FU_TOTAL-1:0]       read_tags;
   logic [NUM_FU_TOTAL-1:0]            read_valid;
   data_t [NUM_FU_TOTAL-1:0]           read_data;
   logic [CDB_SZ-1:0]                  write_en;
   phys_tag_t [CDB_SZ-1:0]             write_tags;
   data_t [CDB_SZ-1:0]                 write_data;
   logic [N-1:0]                       alloc_en;
   phys_tag_t [N-1:0]                  alloc_tags;
   logic                               restore_en;
   logic [NUM_REGS-1:0]                restore_ready;
   logic [NUM_REGS-1:0]                ready_mask;
   logic                               write_conflict;

   modport master (
      output read_en, read_tags, write_en, write_tags, write_data,
             alloc_en, alloc_tags, restore_en, restore_ready,
      input  read_valid, read_data, ready_mask, write_conflict
   );

   modport slave (
      input  read_en, read_tags, write_en, write_tags, write_data,
             alloc_en, alloc_tags, restore_en, restore_ready,
      output read_valid, read_data, ready_mask, write_conflict
   );
endinterface

// File: rtl/prf_ready_table.sv
// Per-tag ready bits: restore beats alloc beats CDB ready-set beats hold; tag 0 is always ready.
module prf_ready_table
   import prf_ready_regfile_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [CDB_SZ-1:0]    write_en,
   input  phys_tag_t [CDB_SZ-1:0] write_tags,
   input  logic [N-1:0]         alloc_en,
   input  phys_tag_t [N-1:0]    alloc_tags,
   input  logic                 restore_en,
   input  logic [NUM_REGS-1:0]  restore_ready,
   output logic [NUM_REGS-1:0]  ready_mask
);
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_tag
         logic set_hit;
         logic clr_hit;
         logic bit_reg;
         logic bit_next;

         always_comb begin
            set_hit  = 1'b0;
            clr_hit  = 1'b0;
            for (int w = 0; w < CDB_SZ; w++)
               if (write_en[w] && write_tags[w] == phys_tag_t'(gi)) set_hit = 1'b1;
            for (int a = 0; a < N; a++)
               if (alloc_en[a] && alloc_tags[a] == phys_tag_t'(gi)) clr_hit = 1'b1;
            bit_next = bit_reg;
            if (restore_en)   bit_next = restore_ready[gi];
            else if (clr_hit) bit_next = 1'b0;
            else if (set_hit) bit_next = 1'b1;
            // The zero register never becomes a real dependency.
            if (gi == 0)      bit_next = 1'b1;
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) bit_reg <= 1'b1;
            else       bit_reg <= bit_next;
         end

         assign ready_mask[gi] = bit_reg;
      end
   endgenerate
endmodule

// File: rtl/prf_ready_regfile.sv
// Physical register file with registered read ports, CDB writeback and integrated ready table.
// Optional macro PRF_WRITE_BYPASS_EN forwards same-cycle CDB writes onto read ports.
module prf_ready_regfile
   import prf_ready_regfile_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   prf_ready_regfile_if.slave bus
);
   data_t entry_reg [NUM_REGS];
   logic  conflict_reg;
   logic  conflict_next;

   // Later loop iterations override earlier ones, so the highest write port wins.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) entry_reg[r] <= '0;
      end else begin
         for (int w = 0; w < CDB_SZ; w++)
            if (bus.write_en[w] && bus.write_tags[w] != '0)
               entry_reg[bus.write_tags[w]] <= bus.write_data[w];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FU_TOTAL; gi++) begin : g_read
         logic  valid_reg;
         data_t data_reg;
         data_t data_next;

         always_comb begin
            data_next = entry_reg[bus.read_tags[gi]];
`ifdef PRF_WRITE_BYPASS_EN
            for (int w = 0; w < CDB_SZ; w++)
               if (bus.write_en[w] && bus.write_tags[w] == bus.read_tags[gi])
                  data_next = bus.write_data[w];
`endif
            if (!bus.read_en[gi] || bus.read_tags[gi] == '0) data_next = '0;
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
            end else begin
               valid_reg <= bus.read_en[gi];
               data_reg  <= data_next;
            end
         end

         assign bus.read_valid[gi] = valid_reg;
         assign bus.read_data[gi]  = data_reg;
      end
   endgenerate

   always_comb begin
      conflict_next = 1'b0;
      for (int i = 0; i < CDB_SZ; i++)
         for (int j = i + 1; j < CDB_SZ; j++)
            if (bus.write_en[i] && bus.write_en[j] &&
                bus.write_tags[i] == bus.write_tags[j] && bus.write_tags[i] != '0)
               conflict_next = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) conflict_reg <= 1'b0;
      else       conflict_reg <= conflict_next;
   end

   assign bus.write_conflict = conflict_reg;

   prf_ready_table u_ready_table (
      .clock         (clock),
      .reset         (reset),
      .write_en      (bus.write_en),
      .write_tags    (bus.write_tags),
      .alloc_en      (bus.alloc_en),
      .alloc_tags    (bus.alloc_tags),
      .restore_en    (bus.restore_en),
      .restore_ready (bus.restore_ready),
      .ready_mask    (bus.ready_mask)
   );
endmodule
